// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router input-side control.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;

  localparam logic [1:0] ADDR_INVALID = 2'b11;
  localparam int NUM_PORTS = 3;

  // Address 3 has no port, so it selects nothing rather than an out-of-range bit.
  function automatic logic portBit(input logic [NUM_PORTS-1:0] flags, input logic [1:0] addr);
    case (addr)
      2'd0:    portBit = flags[0];
      2'd1:    portBit = flags[1];
      2'd2:    portBit = flags[2];
      default: portBit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Bounded wait counter used while a destination FIFO drains.
module router_wait_timer #(
  parameter int WAIT_TIMEOUT = 30,
  parameter int CNT_W        = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at LAST so a lingering enable can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && (cnt_q != LAST))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/router_ctrl_fsm.sv
// Input-side control FSM of the 1x3 router: sequences header, payload,
// full-stall and parity handling, with a bounded wait on a busy destination.
module router_ctrl_fsm
  import router_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 30,
  parameter int CNT_W        = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] soft_reset,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy,
  output logic [1:0] dest_addr,
  output logic       pkt_drop
);

  state_e     state_q, state_d;
  logic [1:0] destAddr_q, destAddr_d;
  logic       pktDrop_q, pktDrop_d;

  logic hdrValid;
  logic srHit;
  logic destEmpty;
  logic timerClear;
  logic timerEnable;
  logic timerExpired;

  assign hdrValid    = pkt_valid && (data_in != ADDR_INVALID);
  assign srHit       = (state_q != DECODE_ADDRESS) && portBit(soft_reset, destAddr_q);
  assign destEmpty   = portBit(fifo_empty, destAddr_q);
  assign timerEnable = (state_q == WAIT_TILL_EMPTY);
  // Cleared unless we are staying in the wait state, so every entry starts at zero.
  assign timerClear  = (state_q != WAIT_TILL_EMPTY) || (state_d != WAIT_TILL_EMPTY);

  router_wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timerClear),
    .enable (timerEnable),
    .expired(timerExpired)
  );

  always_comb begin
    state_d   = state_q;
    pktDrop_d = 1'b0;
    case (state_q)
      DECODE_ADDRESS: begin
        if (hdrValid)
          state_d = portBit(fifo_empty, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)
          state_d = FIFO_FULL_STATE;
        else if (!pkt_valid)
          state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full)
          state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)
          state_d = DECODE_ADDRESS;
        else if (low_packet_valid)
          state_d = LOAD_PARITY;
        else
          state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY: begin
        if (destEmpty) begin
          state_d = LOAD_FIRST_DATA;
        end else if (timerExpired) begin
          state_d   = DECODE_ADDRESS;
          pktDrop_d = 1'b1;
        end
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    // A soft reset on the selected port overrides everything, including a drop.
    if (srHit) begin
      state_d   = DECODE_ADDRESS;
      pktDrop_d = 1'b0;
    end
  end

  assign destAddr_d = ((state_q == DECODE_ADDRESS) && hdrValid) ? data_in : destAddr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= DECODE_ADDRESS;
      destAddr_q <= 2'd0;
      pktDrop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      destAddr_q <= destAddr_d;
      pktDrop_q  <= pktDrop_d;
    end
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;
    case (state_q)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      LOAD_FIRST_DATA: lfd_state = 1'b1;
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      LOAD_PARITY: write_enb_reg = 1'b1;
      FIFO_FULL_STATE: full_state = 1'b1;
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
      default: ;
    endcase
  end

  assign dest_addr = destAddr_q;
  assign pkt_drop  = pktDrop_q;

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Table-driven, scoreboarded bench for router_ctrl_fsm.
module tb_router_ctrl_fsm;
  import router_pkg::*;

  typedef struct {
    string      name;
    logic       rst;
    logic       pv;
    logic [1:0] din;
    logic       ff;
    logic [2:0] fe;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    state_e     expState;
    logic [1:0] expDest;
    logic       expDrop;
  } vec_t;

  typedef struct {
    string       name;
    logic [10:0] outs;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_packet_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy, pkt_drop;
  logic [1:0] dest_addr;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t scoreboard[$];
  vec_t vecs[$];

  always #5 clock = ~clock;

  router_ctrl_fsm #(.WAIT_TIMEOUT(30), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_packet_valid(low_packet_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy), .dest_addr(dest_addr),
    .pkt_drop(pkt_drop)
  );

  // Expected Moore decode, written directly from the output descriptions.
  function automatic logic [10:0] expOut(state_e s, logic [1:0] d, logic drop);
    logic det, lfd, ld, laf, full, ri, we, bsy;
    det  = (s == DECODE_ADDRESS);
    lfd  = (s == LOAD_FIRST_DATA);
    ld   = (s == LOAD_DATA);
    laf  = (s == LOAD_AFTER_FULL);
    full = (s == FIFO_FULL_STATE);
    ri   = (s == CHECK_PARITY_ERROR);
    we   = (s == LOAD_DATA) || (s == LOAD_PARITY) || (s == LOAD_AFTER_FULL);
    bsy  = !((s == DECODE_ADDRESS) || (s == LOAD_DATA));
    return {det, lfd, ld, laf, full, ri, we, bsy, d, drop};
  endfunction

  function automatic vec_t mk(string n, logic r, logic pv, logic [1:0] din, logic ff,
                              logic [2:0] fe, logic [2:0] sr, logic pd, logic lpv,
                              state_e s, logic [1:0] d, logic drop);
    vec_t v;
    v.name = n; v.rst = r; v.pv = pv; v.din = din; v.ff = ff; v.fe = fe; v.sr = sr;
    v.pd = pd; v.lpv = lpv; v.expState = s; v.expDest = d; v.expDrop = drop;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    reset = v.rst; pkt_valid = v.pv; data_in = v.din; fifo_full = v.ff;
    fifo_empty = v.fe; soft_reset = v.sr; parity_done = v.pd; low_packet_valid = v.lpv;
    e.name = v.name;
    e.outs = expOut(v.expState, v.expDest, v.expDrop);
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [10:0] act;
    act = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, dest_addr, pkt_drop};
    compared++;
    if (scoreboard.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_empty: got %b, required a pending expectation", act);
    end else begin
      e = scoreboard.pop_front();
      if (act !== e.outs) begin
        mismatched++;
        $display("[TB] FAIL %s: got %b, required %b (det lfd ld laf full rst we busy dest drop)",
                 e.name, act, e.outs);
      end
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clock);
    applyStimulus(v);
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  // Hold destination 2 non-empty for n cycles inside WAIT_TILL_EMPTY.
  task automatic waitCycles(input int n, input logic [2:0] sr);
    for (int i = 0; i < n; i++)
      step(mk("wte_hold", 0, 1, 2, 0, 3'b000, sr, 0, 0, WAIT_TILL_EMPTY, 2, 0));
  endtask

  task automatic drainFromLfd(input logic [1:0] d);
    step(mk("lfd_to_ld", 0, 0, 0, 0, 3'b111, 0, 0, 0, LOAD_DATA, d, 0));
    step(mk("ld_to_lp", 0, 0, 0, 0, 3'b111, 0, 0, 0, LOAD_PARITY, d, 0));
    step(mk("lp_to_cpe", 0, 0, 0, 0, 3'b111, 0, 0, 0, CHECK_PARITY_ERROR, d, 0));
    step(mk("cpe_to_da", 0, 0, 0, 0, 3'b111, 0, 0, 0, DECODE_ADDRESS, d, 0));
  endtask

  initial begin
    reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_packet_valid = 1'b0;

    // Reset, normal packet to port 1
    vecs.push_back(mk("reset_0", 1, 0, 0, 0, 7, 0, 0, 0, DECODE_ADDRESS, 0, 0));
    vecs.push_back(mk("reset_1", 1, 0, 0, 0, 7, 0, 0, 0, DECODE_ADDRESS, 0, 0));
    vecs.push_back(mk("hdr_p1", 0, 1, 1, 0, 7, 0, 0, 0, LOAD_FIRST_DATA, 1, 0));
    vecs.push_back(mk("lfd_ld", 0, 1, 2, 0, 7, 0, 0, 0, LOAD_DATA, 1, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("payload", 0, 1, 2'(i), 0, 7, 0, 0, 0, LOAD_DATA, 1, 0));
    vecs.push_back(mk("to_parity", 0, 0, 0, 0, 7, 0, 0, 0, LOAD_PARITY, 1, 0));
    vecs.push_back(mk("to_check", 0, 0, 0, 0, 7, 0, 0, 0, CHECK_PARITY_ERROR, 1, 0));
    vecs.push_back(mk("to_decode", 0, 0, 0, 0, 7, 0, 0, 0, DECODE_ADDRESS, 1, 0));
    // Full stall, low_packet_valid exit
    vecs.push_back(mk("fsA_hdr", 0, 1, 1, 0, 7, 0, 0, 0, LOAD_FIRST_DATA, 1, 0));
    vecs.push_back(mk("fsA_ld", 0, 1, 0, 0, 7, 0, 0, 0, LOAD_DATA, 1, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("fsA_full", 0, 1, 0, 1, 7, 0, 0, 0, FIFO_FULL_STATE, 1, 0));
    vecs.push_back(mk("fsA_laf", 0, 0, 0, 0, 7, 0, 0, 0, LOAD_AFTER_FULL, 1, 0));
    vecs.push_back(mk("fsA_lpv", 0, 0, 0, 0, 7, 0, 0, 1, LOAD_PARITY, 1, 0));
    vecs.push_back(mk("fsA_cpe", 0, 0, 0, 0, 7, 0, 0, 0, CHECK_PARITY_ERROR, 1, 0));
    vecs.push_back(mk("fsA_da", 0, 0, 0, 0, 7, 0, 0, 0, DECODE_ADDRESS, 1, 0));
    // Full stall, parity_done beats low_packet_valid
    vecs.push_back(mk("fsB_hdr", 0, 1, 1, 0, 7, 0, 0, 0, LOAD_FIRST_DATA, 1, 0));
    vecs.push_back(mk("fsB_ld", 0, 1, 0, 0, 7, 0, 0, 0, LOAD_DATA, 1, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("fsB_full", 0, 1, 0, 1, 7, 0, 0, 0, FIFO_FULL_STATE, 1, 0));
    vecs.push_back(mk("fsB_laf", 0, 0, 0, 0, 7, 0, 0, 0, LOAD_AFTER_FULL, 1, 0));
    vecs.push_back(mk("fsB_pd", 0, 0, 0, 0, 7, 0, 1, 1, DECODE_ADDRESS, 1, 0));
    // Port 0: full beats !pkt_valid, LAF fall-through, full in CHECK_PARITY_ERROR
    vecs.push_back(mk("p0_hdr", 0, 1, 0, 0, 7, 0, 0, 0, LOAD_FIRST_DATA, 0, 0));
    vecs.push_back(mk("p0_ld", 0, 1, 0, 0, 7, 0, 0, 0, LOAD_DATA, 0, 0));
    vecs.push_back(mk("full_wins", 0, 0, 0, 1, 7, 0, 0, 0, FIFO_FULL_STATE, 0, 0));
    vecs.push_back(mk("p0_laf", 0, 0, 0, 0, 7, 0, 0, 0, LOAD_AFTER_FULL, 0, 0));
    vecs.push_back(mk("laf_to_ld", 0, 1, 0, 0, 7, 0, 0, 0, LOAD_DATA, 0, 0));
    vecs.push_back(mk("p0_lp", 0, 0, 0, 0, 7, 0, 0, 0, LOAD_PARITY, 0, 0));
    vecs.push_back(mk("lp_ignores_ff", 0, 0, 0, 1, 7, 0, 0, 0, CHECK_PARITY_ERROR, 0, 0));
    vecs.push_back(mk("cpe_full", 0, 0, 0, 1, 7, 0, 0, 0, FIFO_FULL_STATE, 0, 0));
    vecs.push_back(mk("p0_laf2", 0, 0, 0, 0, 7, 0, 0, 0, LOAD_AFTER_FULL, 0, 0));
    vecs.push_back(mk("p0_lpv", 0, 0, 0, 0, 7, 0, 0, 1, LOAD_PARITY, 0, 0));
    vecs.push_back(mk("p0_cpe", 0, 0, 0, 0, 7, 0, 0, 0, CHECK_PARITY_ERROR, 0, 0));
    vecs.push_back(mk("p0_da", 0, 0, 0, 0, 7, 0, 0, 0, DECODE_ADDRESS, 0, 0));
    // Soft resets, invalid address, reset over soft reset
    vecs.push_back(mk("sr_hdr", 0, 1, 1, 0, 7, 0, 0, 0, LOAD_FIRST_DATA, 1, 0));
    vecs.push_back(mk("sr_ld", 0, 1, 0, 0, 7, 0, 0, 0, LOAD_DATA, 1, 0));
    vecs.push_back(mk("sr_other_port", 0, 1, 0, 0, 7, 3'b100, 0, 0, LOAD_DATA, 1, 0));
    vecs.push_back(mk("sr_own_port", 0, 1, 0, 1, 7, 3'b010, 0, 0, DECODE_ADDRESS, 1, 0));
    vecs.push_back(mk("addr_invalid", 0, 1, 3, 0, 7, 0, 0, 0, DECODE_ADDRESS, 1, 0));
    vecs.push_back(mk("no_pkt_valid", 0, 0, 2, 0, 7, 0, 0, 0, DECODE_ADDRESS, 1, 0));
    vecs.push_back(mk("sr_in_decode", 0, 1, 1, 0, 7, 3'b010, 0, 0, LOAD_FIRST_DATA, 1, 0));
    vecs.push_back(mk("sr_in_lfd", 0, 1, 0, 0, 7, 3'b010, 0, 0, DECODE_ADDRESS, 1, 0));
    vecs.push_back(mk("hdr_p2", 0, 1, 2, 0, 7, 0, 0, 0, LOAD_FIRST_DATA, 2, 0));
    vecs.push_back(mk("p2_ld", 0, 1, 0, 0, 7, 0, 0, 0, LOAD_DATA, 2, 0));
    vecs.push_back(mk("reset_over_sr", 1, 1, 0, 0, 7, 3'b100, 0, 0, DECODE_ADDRESS, 0, 0));

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i]);

    // Port 2 busy, drains on the fifth wait cycle
    step(mk("wte_enter", 0, 1, 2, 0, 3'b011, 0, 0, 0, WAIT_TILL_EMPTY, 2, 0));
    for (int i = 0; i < 4; i++)
      step(mk("wte_wait", 0, 1, 2, 0, 3'b011, 0, 0, 0, WAIT_TILL_EMPTY, 2, 0));
    step(mk("wte_release", 0, 1, 2, 0, 3'b111, 0, 0, 0, LOAD_FIRST_DATA, 2, 0));
    drainFromLfd(2);

    // Timeout: drop pulse lands 30 cycles after entry
    step(mk("to_enter", 0, 1, 2, 0, 3'b000, 0, 0, 0, WAIT_TILL_EMPTY, 2, 0));
    waitCycles(29, 3'b000);
    step(mk("to_drop", 0, 1, 2, 0, 3'b000, 0, 0, 0, DECODE_ADDRESS, 2, 1));
    step(mk("to_drop_clear", 0, 0, 0, 0, 3'b000, 0, 0, 0, DECODE_ADDRESS, 2, 0));

    // Empty coincides with timeout: empty wins, no drop
    step(mk("co_enter", 0, 1, 2, 0, 3'b000, 0, 0, 0, WAIT_TILL_EMPTY, 2, 0));
    waitCycles(29, 3'b000);
    step(mk("co_empty_wins", 0, 1, 2, 0, 3'b100, 0, 0, 0, LOAD_FIRST_DATA, 2, 0));
    drainFromLfd(2);

    // Soft reset in the wait state restarts the timeout from zero
    step(mk("srw_enter", 0, 1, 2, 0, 3'b000, 0, 0, 0, WAIT_TILL_EMPTY, 2, 0));
    waitCycles(10, 3'b010);
    step(mk("srw_abort", 0, 1, 2, 0, 3'b000, 3'b100, 0, 0, DECODE_ADDRESS, 2, 0));
    step(mk("srw_reenter", 0, 1, 2, 0, 3'b000, 0, 0, 0, WAIT_TILL_EMPTY, 2, 0));
    waitCycles(29, 3'b000);
    step(mk("srw_drop", 0, 1, 2, 0, 3'b000, 0, 0, 0, DECODE_ADDRESS, 2, 1));
    step(mk("srw_idle", 0, 0, 0, 0, 3'b000, 0, 0, 0, DECODE_ADDRESS, 2, 0));

    if (scoreboard.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_leftover: got %0d pending, required 0", scoreboard.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/router_ctrl_fsm.md
Name: router_ctrl_fsm

Overview:
- Control state machine for the 1x3 router input side.
- Sequences the packet register/parity datapath: header detect, first-data load, payload load, full-stall, load-after-full, parity load and parity check.
- Selects the destination port from header bits [1:0], waits for that port's FIFO to drain, and honours per-port soft resets.
- Adds a bounded wait with a drop indication so a stuck destination cannot hang the input.

Parameters:
- WAIT_TIMEOUT, 30, max cycles spent in WAIT_TILL_EMPTY before the packet is dropped (1..255).
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > WAIT_TIMEOUT.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- pkt_valid  in  1  source asserts while header/payload bytes are valid; drops for the parity byte
- data_in  in  2  header address field (data bus bits [1:0]); 2'b11 is invalid
- fifo_full  in  1  FIFO full for the currently selected port
- fifo_empty  in  3  per-port FIFO empty flags
- soft_reset  in  3  per-port soft-reset pulses from the read-side synchroniser
- parity_done  in  1  from the packet register: parity byte captured
- low_packet_valid  in  1  from the packet register: packet ended during a full stall
- detect_add  out  1  high in DECODE_ADDRESS
- lfd_state  out  1  high in LOAD_FIRST_DATA
- ld_state  out  1  high in LOAD_DATA
- laf_state  out  1  high in LOAD_AFTER_FULL
- full_state  out  1  high in FIFO_FULL_STATE
- rst_int_reg  out  1  high in CHECK_PARITY_ERROR
- write_enb_reg  out  1  high in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL
- busy  out  1  high in every state except DECODE_ADDRESS and LOAD_DATA
- dest_addr  out  2  latched destination port
- pkt_drop  out  1  one-cycle pulse when a WAIT_TILL_EMPTY timeout discards a packet

Behaviour:
- Moore outputs are decoded from the state register only, so a state change shows on the outputs in the cycle after the causing input.
- Reset (and power-up, assuming reset is held): state=DECODE_ADDRESS, dest_addr=0, wait counter=0, pkt_drop=0. Output values during reset: detect_add=1, all other outputs 0.
- dest_addr loads data_in in DECODE_ADDRESS when pkt_valid=1 and data_in!=3. It holds its value in all other states.
- DECODE_ADDRESS:
  - pkt_valid & addr!=3 & fifo_empty[addr] -> LOAD_FIRST_DATA.
  - pkt_valid & addr!=3 & !fifo_empty[addr] -> WAIT_TILL_EMPTY.
  - Anything else, including addr=3, stays in DECODE_ADDRESS (no load).
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
- LOAD_DATA:
  - fifo_full -> FIFO_FULL_STATE.
  - Otherwise, !pkt_valid -> LOAD_PARITY.
  - Otherwise, stay.
  - If fifo_full and !pkt_valid occur together, fifo_full wins.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; otherwise stay.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS.
  - Otherwise, low_packet_valid -> LOAD_PARITY.
  - Otherwise -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; otherwise -> DECODE_ADDRESS.
- WAIT_TILL_EMPTY:
  - Wait counter clears on entry and increments each cycle spent here.
  - fifo_empty[dest_addr] -> LOAD_FIRST_DATA.
  - Otherwise, if counter==WAIT_TIMEOUT-1 -> DECODE_ADDRESS with pkt_drop=1 for exactly that transition cycle.
  - If empty and timeout coincide, empty wins and there is no drop.
- Soft reset:
  - soft_reset[dest_addr]=1 in any state except DECODE_ADDRESS forces the next state to DECODE_ADDRESS.
  - It has priority over all other transitions and clears the wait counter.
  - Soft resets on non-selected ports are ignored.
- reset has priority over soft_reset.
- The state encoding is binary, 3 bits, 8 states. Any illegal encoding recovers to DECODE_ADDRESS on the next cycle.

Decomposition:
- Shared package router_pkg holds:
  - the state enum (DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR);
  - the constant ADDR_INVALID=2'b11;
  - the constant NUM_PORTS=3.
- The state register, next-state logic and output decode live in this module.
- The wait timer is one sub-module, router_wait_timer:
  - inputs: clear, enable;
  - output: expired;
  - parameters: WAIT_TIMEOUT, CNT_W.

Test Plan:
- Reset held for 2 cycles, then pkt_valid=1, data_in=2'b01, fifo_empty=3'b111:
  - expect detect_add=1 during reset;
  - then LOAD_FIRST_DATA (lfd_state=1, busy=1), then LOAD_DATA (ld_state=1, busy=0);
  - dest_addr=1.
- 4-byte payload then pkt_valid=0, fifo_full=0:
  - expect LOAD_PARITY (write_enb_reg=1) for 1 cycle;
  - then CHECK_PARITY_ERROR (rst_int_reg=1) for 1 cycle;
  - then DECODE_ADDRESS.
- Full stall, fifo_full=1 in LOAD_DATA for 3 cycles:
  - expect full_state=1 for 3 cycles, then laf_state=1.
  - With low_packet_valid=1 and parity_done=0: next is LOAD_PARITY.
  - Repeat with parity_done=1: next is DECODE_ADDRESS.
- Addr 2, fifo_empty[2]=0:
  - expect WAIT_TILL_EMPTY;
  - fifo_empty[2] rises at cycle 5 -> LOAD_FIRST_DATA, no pkt_drop.
- Addr 2 held non-empty with WAIT_TIMEOUT=30:
  - expect a single pkt_drop pulse exactly 30 cycles after entering WAIT_TILL_EMPTY, then detect_add=1.
- Soft reset:
  - soft_reset=3'b010 with dest_addr=1 in LOAD_DATA -> DECODE_ADDRESS next cycle.
  - soft_reset=3'b100 with dest_addr=1 -> no effect.
  - data_in=2'b11 with pkt_valid=1 -> stays in DECODE_ADDRESS.
